usb_fs_tx: RTL and testbench

//  Full-speed USB packet transmitter; the outbound counterpart of the device receive path.

---
 rtl/usb_fs_tx.sv | 179 +++++++++++++++++
 tb/tb_usb_fs_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx.sv
// Full-speed USB transmitter: byte stream in, SYNC + stuffed NRZI bits + EOP out.
// Line level is kept as NRZI level plus an SE0 flag; pads are derived from both.
module usb_fs_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic [6:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          under_q, under_d;
    logic          lvl_q, lvl_d;
    logic          se0_q, se0_d;
    logic          oe_q, oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tick;
    logic          send_bit;
    logic          bit_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            under_q    <= 1'b0;
            lvl_q      <= 1'b1;
            se0_q      <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            under_q    <= under_d;
            lvl_q      <= lvl_d;
            se0_q      <= se0_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        last_d     = last_q;
        under_d    = under_q;
        lvl_d      = lvl_q;
        se0_d      = se0_q;
        oe_d       = oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tx_ready   = 1'b0;
        send_bit   = 1'b0;
        bit_val    = 1'b0;

        tick = (state_q != IDLE) && (tick_cnt_q == CW'(CLKS_PER_BIT - 1));
        if (state_q != IDLE)
            tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    // SYNC is 8'h80 LSB first: its first bit goes out here, the rest via the shifter
                    state_d    = SYNC;
                    oe_d       = 1'b1;
                    tick_cnt_d = '0;
                    shift_d    = 7'h40;
                    bit_cnt_d  = 4'd1;
                    last_d     = 1'b0;
                    under_d    = 1'b0;
                    send_bit   = 1'b1;
                    bit_val    = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (tick) begin
                    if (ones_q == 3'd6) begin
                        lvl_d  = ~lvl_q;
                        ones_d = '0;
                    end else if (bit_cnt_q == 4'd8) begin
                        if (last_q) begin
                            state_d   = EOP;
                            se0_d     = 1'b1;
                            bit_cnt_d = '0;
                        end else if (tx_valid) begin
                            state_d   = DATA;
                            tx_ready  = 1'b1;
                            send_bit  = 1'b1;
                            bit_val   = tx_data[0];
                            shift_d   = tx_data[7:1];
                            last_d    = tx_last;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = EOP;
                            se0_d     = 1'b1;
                            bit_cnt_d = '0;
                            under_d   = 1'b1;
                        end
                    end else begin
                        send_bit  = 1'b1;
                        bit_val   = shift_q[0];
                        shift_d   = {1'b0, shift_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            EOP: begin
                if (tick) begin
                    case (bit_cnt_q)
                        4'd0: bit_cnt_d = 4'd1;
                        4'd1: begin
                            se0_d     = 1'b0;
                            lvl_d     = 1'b1;
                            bit_cnt_d = 4'd2;
                        end
                        default: begin
                            state_d   = IDLE;
                            oe_d      = 1'b0;
                            done_d    = ~under_q;
                            err_d     = under_q;
                            bit_cnt_d = '0;
                            ones_d    = '0;
                            shift_d   = '0;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        if (send_bit) begin
            if (bit_val) begin
                ones_d = ones_q + 3'd1;
            end else begin
                lvl_d  = ~lvl_q;
                ones_d = '0;
            end
        end
    end

    assign usb_dp  = ~se0_q & lvl_q;
    assign usb_dn  = ~se0_q & ~lvl_q;
    assign usb_oe  = oe_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_usb_fs_tx.sv
// Bench for usb_fs_tx: directed and random packets on CPB=4 and CPB=1 instances,
// checked cycle by cycle against a line-symbol model built from bit-level rules.
module tb_usb_fs_tx;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;

    logic v4, r4, dp4, dn4, oe4, b4, d4, e4;
    logic v1, r1, dp1, dn1, oe1, b1, d1, e1;
    logic ready_m, dp_m, dn_m, oe_m, busy_m, done_m, err_m;

    assign v4 = tx_valid & ~sel;
    assign v1 = tx_valid & sel;

    usb_fs_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .tx_valid(v4), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(r4), .usb_dp(dp4), .usb_dn(dn4), .usb_oe(oe4),
        .tx_busy(b4), .tx_done(d4), .tx_err(e4)
    );

    usb_fs_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(r1), .usb_dp(dp1), .usb_dn(dn1), .usb_oe(oe1),
        .tx_busy(b1), .tx_done(d1), .tx_err(e1)
    );

    assign ready_m = sel ? r1  : r4;
    assign dp_m    = sel ? dp1 : dp4;
    assign dn_m    = sel ? dn1 : dn4;
    assign oe_m    = sel ? oe1 : oe4;
    assign busy_m  = sel ? b1  : b4;
    assign done_m  = sel ? d1  : d4;
    assign err_m   = sel ? e1  : e4;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pkt[$];
    logic [1:0] exp_syms[$];
    int         exp_rdy[$];
    logic [1:0] obs_sym[$];
    int         obs_rdy[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: emit SYNC then fed bytes LSB first, insert a toggle after six ones, NRZI from J.
    task automatic build_model(input int cpb, input int n_feed);
        int lvl;
        int ones;
        logic [7:0] b;
        lvl  = 1;
        ones = 0;
        exp_syms.delete();
        exp_rdy.delete();
        for (int j = -1; j < n_feed; j++) begin
            if (j < 0) b = 8'h80;
            else begin
                b = pkt[j];
                exp_rdy.push_back(exp_syms.size() * cpb - 1);
            end
            for (int i = 0; i < 8; i++) begin
                if (b[i]) ones++;
                else begin
                    lvl  = 1 - lvl;
                    ones = 0;
                end
                exp_syms.push_back(lvl != 0 ? SYM_J : SYM_K);
                if (ones == 6) begin
                    lvl  = 1 - lvl;
                    ones = 0;
                    exp_syms.push_back(lvl != 0 ? SYM_J : SYM_K);
                end
            end
        end
        exp_syms.push_back(SYM_SE0);
        exp_syms.push_back(SYM_SE0);
        exp_syms.push_back(SYM_J);
    endtask

    task automatic drive(input int n_feed);
        int i;
        i = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = pkt[0];
        tx_last  = (pkt.size() == 1);
        for (int c = 0; c < 3000 && i < n_feed; c++) begin
            @(negedge clk);
            if (ready_m) begin
                i++;
                @(posedge clk);
                #1;
                if (i < n_feed) begin
                    tx_data = pkt[i];
                    tx_last = (i == pkt.size() - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic run_packet(input int n_feed, input string name);
        int   cpb;
        int   end_c;
        logic de, ee, oe_end, busy_end, busy0, started;
        cpb      = sel ? 1 : 4;
        end_c    = -1;
        de       = 1'b0;
        ee       = 1'b0;
        oe_end   = 1'b1;
        busy_end = 1'b1;
        busy0    = 1'b0;
        started  = 1'b0;
        build_model(cpb, n_feed);
        obs_sym.delete();
        obs_rdy.delete();
        fork
            drive(n_feed);
            begin
                for (int w = 0; w < 100 && !started; w++) begin
                    @(negedge clk);
                    started = oe_m;
                end
                if (started) begin
                    for (int c = 0; c < 3000; c++) begin
                        if (done_m || err_m) begin
                            end_c    = c;
                            de       = done_m;
                            ee       = err_m;
                            oe_end   = oe_m;
                            busy_end = busy_m;
                            break;
                        end
                        if (c == 0) busy0 = busy_m;
                        obs_sym.push_back({dp_m, dn_m});
                        if (ready_m) obs_rdy.push_back(c);
                        @(negedge clk);
                    end
                end
            end
        join
        check({name, "_start"}, 32'(started), 32'd1);
        check({name, "_len"}, end_c, exp_syms.size() * cpb);
        foreach (obs_sym[c])
            if (c / cpb < exp_syms.size())
                check($sformatf("%s_sym%0d", name, c), 32'(obs_sym[c]), 32'(exp_syms[c / cpb]));
        check({name, "_nready"}, obs_rdy.size(), exp_rdy.size());
        foreach (obs_rdy[k])
            if (k < exp_rdy.size())
                check($sformatf("%s_rdy%0d", name, k), obs_rdy[k], exp_rdy[k]);
        check({name, "_done"}, 32'(de), 32'(n_feed == pkt.size()));
        check({name, "_err"}, 32'(ee), 32'(n_feed != pkt.size()));
        check({name, "_oe_end"}, 32'(oe_end), 32'd0);
        check({name, "_busy_start"}, 32'(busy0), 32'd1);
        check({name, "_busy_end"}, 32'(busy_end), 32'd0);
        @(negedge clk);
        check({name, "_idle_pulse"}, 32'({done_m, err_m, oe_m}), 32'd0);
    endtask

    task automatic check_idle_line(input string name);
        check({name, "_oe"}, 32'(oe_m), 32'd0);
        check({name, "_line"}, 32'({dp_m, dn_m}), 32'(SYM_J));
        check({name, "_busy"}, 32'(busy_m), 32'd0);
        check({name, "_flags"}, 32'({ready_m, done_m, err_m}), 32'd0);
    endtask

    task automatic random_packet(input string name);
        int len;
        int n_feed;
        len = $urandom_range(1, 4);
        pkt.delete();
        for (int i = 0; i < len; i++)
            pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        n_feed = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : len;
        run_packet(n_feed, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_line("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        check_idle_line("rst_rel");

        pkt = {8'h00};
        run_packet(1, "t1");
        pkt = {8'hFF};
        run_packet(1, "t2");
        pkt = {8'hC3, 8'h5A, 8'h81};
        run_packet(3, "t3");
        pkt = {8'h2D, 8'h00};
        run_packet(1, "t4");

        // Abort mid-byte with the reset line, then resend the single-byte packet.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        tx_last  = 1'b1;
        repeat (45) @(negedge clk);
        check("t5_pre_oe", 32'(oe_m), 32'd1);
        #2 rst = 1'b0;
        #1 check_idle_line("t5_rst");
        tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pkt = {8'h00};
        run_packet(1, "t5_after");

        for (int r = 0; r < 5; r++) random_packet($sformatf("rnd4_%0d", r));

        sel = 1'b1;
        @(negedge clk);
        pkt = {8'hC3, 8'h5A, 8'h81};
        run_packet(3, "t6");
        pkt = {8'hFF, 8'hFF};
        run_packet(2, "t6_ff");
        for (int r = 0; r < 4; r++) random_packet($sformatf("rnd1_%0d", r));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
